// File: rtl/acl_spi_defs_pkg.sv
// rtl/acl_spi_defs_pkg.sv - shared register map and FSM encodings for the ADXL345-style SPI link
package acl_spi_defs;

   // Register map shared with the reader master
   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAX1      = 6'h33;
   localparam logic [5:0] ADDR_DATAY0      = 6'h34;
   localparam logic [5:0] ADDR_DATAY1      = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

   // Transaction FSM encodings
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   // Only the three configuration registers accept writes
   function automatic logic is_writable(input logic [5:0] a);
      return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) || (a == ADDR_DATA_FORMAT);
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-flop synchronizer with rise/fall detection for one SPI pin
module spi_in_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              q_d;

   // Shift the pin through the synchronizer chain and keep one delayed copy for edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {STAGES{RST_VAL}};
         q_d    <= RST_VAL;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         q_d    <= sync_r[STAGES-1];
      end
   end

   assign q    = sync_r[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/acl_spi_responder.sv
// rtl/acl_spi_responder.sv - SPI mode-3 slave emulating an ADXL345-style accelerometer
module acl_spi_responder #(
   parameter logic [7:0] DEVID_VAL   = 8'hE5,
   parameter logic [7:0] BW_RATE_RST = 8'h0A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CSN,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] x_sample,
   input  logic [15:0] y_sample,
   input  logic [15:0] z_sample,
   output logic [7:0]  power_ctl,
   output logic [7:0]  bw_rate,
   output logic [7:0]  data_format,
   output logic        wr_strobe,
   output logic        busy
);

   import acl_spi_defs::*;

   logic        csn_q, csn_rise, csn_fall;
   logic        sclk_q, sclk_rise, sclk_fall;
   logic        mosi_q, mosi_rise, mosi_fall;
   logic        unused_sync;

   logic [1:0]  state;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_in;
   logic [7:0]  shift_out;
   logic        rw;
   logic        mb;
   logic [5:0]  addr;
   logic [47:0] snap;

   logic [7:0]  sh_next;
   logic [5:0]  addr_next;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
      .clk(clk), .rst(rst), .din(CSN), .q(csn_q), .rise(csn_rise), .fall(csn_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
   );

   // SCLK level and MOSI edges are not needed; only edges of SCLK and the MOSI level matter
   assign unused_sync = &{1'b0, sclk_q, mosi_rise, mosi_fall};

   assign busy      = ~csn_q;
   assign sh_next   = {shift_in[6:0], mosi_q};
   assign addr_next = mb ? addr + 6'd1 : addr;

   // Readable map; data registers come from the snapshot taken at CSN fall
   function automatic logic [7:0] rd(input logic [5:0] a);
      case (a)
         ADDR_DEVID:       rd = DEVID_VAL;
         ADDR_BW_RATE:     rd = bw_rate;
         ADDR_POWER_CTL:   rd = power_ctl;
         ADDR_DATA_FORMAT: rd = data_format;
         ADDR_DATAX0:      rd = snap[7:0];
         ADDR_DATAX1:      rd = snap[15:8];
         ADDR_DATAY0:      rd = snap[23:16];
         ADDR_DATAY1:      rd = snap[31:24];
         ADDR_DATAZ0:      rd = snap[39:32];
         ADDR_DATAZ1:      rd = snap[47:40];
         default:          rd = 8'h00;
      endcase
   endfunction

   // Transaction FSM, shift registers and register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         shift_in    <= 8'h00;
         shift_out   <= 8'h00;
         rw          <= 1'b0;
         mb          <= 1'b0;
         addr        <= 6'h00;
         snap        <= 48'h0;
         MISO        <= 1'b0;
         wr_strobe   <= 1'b0;
         power_ctl   <= 8'h00;
         bw_rate     <= BW_RATE_RST;
         data_format <= 8'h00;
      end else begin
         wr_strobe <= 1'b0;
         if (csn_rise) begin
            // End of transaction: any partial byte is dropped here
            state   <= IDLE;
            bit_cnt <= 3'd0;
            MISO    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (csn_fall) begin
                     state   <= CMD;
                     bit_cnt <= 3'd0;
                     snap    <= {z_sample, y_sample, x_sample};
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     shift_in <= sh_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rw    <= sh_next[7];
                        mb    <= sh_next[6];
                        addr  <= sh_next[5:0];
                        state <= DATA;
                        if (sh_next[7])
                           shift_out <= rd(sh_next[5:0]);
                     end
                  end
               end
               DATA: begin
                  if (sclk_fall && rw) begin
                     MISO      <= shift_out[7];
                     shift_out <= {shift_out[6:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     shift_in <= sh_next;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (!rw) begin
                           if (addr == ADDR_BW_RATE)     bw_rate     <= sh_next;
                           if (addr == ADDR_POWER_CTL)   power_ctl   <= sh_next;
                           if (addr == ADDR_DATA_FORMAT) data_format <= sh_next;
                           wr_strobe <= is_writable(addr);
                        end else begin
                           shift_out <= rd(addr_next);
                        end
                        addr <= addr_next;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
